// File: rtl/module_conv_psum_accum_1x2_pkg.sv
// Shared definitions for the 1x2 conv partial-sum accumulator.
//   Widths   : PSUM_W (kernel sum), Q_W (int8 output), PIX_W, TILE_W
//   Constants: sat18 clamp bounds, requant clamp bounds
//   Helpers  : sat18(), post_process() (leaky-ReLU + round-shift + int8 clamp)
//   Types    : state_t (job FSM)
package module_conv_psum_accum_1x2_pkg;

   localparam int PSUM_W = 18;
   localparam int Q_W    = 8;
   localparam int PIX_W  = 12;
   localparam int TILE_W = 6;
   localparam int SUM_W  = PSUM_W + 1;  // one guard bit for the adder
   localparam int PP_W   = 20;          // headroom for the rounding term

   localparam logic signed [SUM_W-1:0] SAT_MAX = 19'sd131071;
   localparam logic signed [SUM_W-1:0] SAT_MIN = -19'sd131072;
   localparam logic signed [PP_W-1:0]  Q_MAX   = 20'sd127;
   localparam logic signed [PP_W-1:0]  Q_MIN   = -20'sd128;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,    // accepting kernel transfers
      ST_DRAIN,  // all inputs taken, flushing S1/S2
      ST_EMPTY   // zero-sized job, one busy cycle
   } state_t;

   function automatic logic signed [PSUM_W-1:0] sat18(input logic signed [SUM_W-1:0] s);
      logic signed [SUM_W-1:0] c;
      c = s;
      if (s > SAT_MAX)
         c = SAT_MAX;
      else if (s < SAT_MIN)
         c = SAT_MIN;
      return c[PSUM_W-1:0];
   endfunction

   function automatic logic [Q_W-1:0] post_process(input logic signed [PSUM_W-1:0] x,
                                                    input logic [3:0]               shift,
                                                    input logic                     leaky);
      logic signed [PP_W-1:0] v;
      v = PP_W'(x);
      if (leaky && x[PSUM_W-1])
         v = v >>> 3;
      if (shift != 4'd0)
         v = v + (PP_W'(1) << (shift - 4'd1));
      v = v >>> shift;
      if (v > Q_MAX)
         v = Q_MAX;
      else if (v < Q_MIN)
         v = Q_MIN;
      return v[Q_W-1:0];
   endfunction

endpackage

// File: rtl/module_psum_ram_4096x36.sv
// Simple dual-port partial-sum RAM, registered read (latency 1), no reset
// on the array or read register so it maps onto block RAM.
//   clk      : clock
//   i_we     : write enable,  i_waddr / i_wdata
//   i_re     : read enable,   i_raddr -> o_rdata next cycle (held when i_re=0)
// A read and write to the same address in one cycle returns the old data.
module module_psum_ram_4096x36 #(
   parameter int AW = 12,
   parameter int DW = 36
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
      if (i_re)
         o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/module_conv_psum_accum_1x2.sv
// Accumulates two 18-bit channel partial sums over cfg_tiles input-channel
// groups, then applies leaky-ReLU and requantization to int8 on the last tile.
//   clk, rst_n            : clock, async active-low reset
//   start, cfg_*          : job launch and configuration (latched on start)
//   in_valid/in_ready     : kernel stream, in_ch1/in_ch2 signed 18-bit
//   out_valid/out_ready   : writer stream, out_data = {ch2_q, ch1_q}
//   busy, done            : job status; done pulses once at job end
// Pipeline: S1 = RAM read result + add, S2 = output register.
module module_conv_psum_accum_1x2
   import module_conv_psum_accum_1x2_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [PIX_W-1:0]  cfg_pixels,
   input  logic [TILE_W-1:0] cfg_tiles,
   input  logic [3:0]        cfg_shift,
   input  logic              cfg_leaky_en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PSUM_W-1:0] in_ch1,
   input  logic [PSUM_W-1:0] in_ch2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*Q_W-1:0]  out_data,
   output logic              busy,
   output logic              done
);

   state_t r_state, w_state_nxt;
   logic   w_done_nxt, r_done;

   logic [PIX_W-1:0]  r_cfg_pixels;
   logic [TILE_W-1:0] r_cfg_tiles;
   logic [3:0]        r_cfg_shift;
   logic              r_cfg_leaky;
   logic [PIX_W-1:0]  r_pix;
   logic [TILE_W-1:0] r_tile;

   logic w_adv, w_in_fire, w_pix_last, w_tile_last, w_tile_first;

   logic                     r_s1_valid, r_s1_first, r_s1_last, r_s1_fwd;
   logic [PIX_W-1:0]         r_s1_pix;
   logic signed [PSUM_W-1:0] r_s1_ch1, r_s1_ch2;
   logic [2*PSUM_W-1:0]      r_s1_fwd_data;

   logic [2*PSUM_W-1:0]      w_rd_data, w_base, w_wdata;
   logic signed [PSUM_W-1:0] w_base_ch1, w_base_ch2, w_sum1, w_sum2;
   logic [Q_W-1:0]           w_q1, w_q2;
   logic                     w_we;

   logic             r_s2_valid;
   logic [2*Q_W-1:0] r_s2_data;

   // The pipeline advances unless S2 holds an output the writer refuses.
   always_comb begin
      w_adv        = !r_s2_valid || out_ready;
      busy         = (r_state != ST_IDLE);
      in_ready     = (r_state == ST_RUN) && w_adv;
      w_in_fire    = in_valid && in_ready;
      w_pix_last   = (r_pix == r_cfg_pixels - 12'd1);
      w_tile_last  = (r_tile == r_cfg_tiles - 6'd1);
      w_tile_first = (r_tile == '0);
      out_valid    = r_s2_valid;
      out_data     = r_s2_data;
      done         = r_done;
   end

   // ---------------- job FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE:
            if (start)
               w_state_nxt = (cfg_pixels == '0 || cfg_tiles == '0) ? ST_EMPTY : ST_RUN;
         ST_RUN:
            if (w_in_fire && w_pix_last && w_tile_last)
               w_state_nxt = ST_DRAIN;
         ST_DRAIN:
            // Last output leaves S2 with nothing behind it in S1.
            if (r_s2_valid && out_ready && !r_s1_valid) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         ST_EMPTY: begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- config and counters ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cfg_pixels <= '0;
         r_cfg_tiles  <= '0;
         r_cfg_shift  <= '0;
         r_cfg_leaky  <= 1'b0;
         r_pix        <= '0;
         r_tile       <= '0;
      end else if (r_state == ST_IDLE && start) begin
         r_cfg_pixels <= cfg_pixels;
         r_cfg_tiles  <= cfg_tiles;
         r_cfg_shift  <= cfg_shift;
         r_cfg_leaky  <= cfg_leaky_en;
         r_pix        <= '0;
         r_tile       <= '0;
      end else if (w_in_fire) begin
         if (w_pix_last) begin
            r_pix  <= '0;
            r_tile <= r_tile + 6'd1;
         end else begin
            r_pix <= r_pix + 12'd1;
         end
      end
   end

   // ---------------- psum RAM ----------------
   module_psum_ram_4096x36 #(
      .AW (PIX_W),
      .DW (2*PSUM_W)
   ) u_psum_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_s1_pix),
      .i_wdata (w_wdata),
      .i_re    (w_in_fire),
      .i_raddr (r_pix),
      .o_rdata (w_rd_data)
   );

   // ---------------- S1: accumulate ----------------
   // Reads are only issued on a transfer, so a stall leaves the RAM
   // output register holding the data S1 still needs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid    <= 1'b0;
         r_s1_first    <= 1'b0;
         r_s1_last     <= 1'b0;
         r_s1_fwd      <= 1'b0;
         r_s1_pix      <= '0;
         r_s1_ch1      <= '0;
         r_s1_ch2      <= '0;
         r_s1_fwd_data <= '0;
      end else if (w_adv) begin
         r_s1_valid <= w_in_fire;
         if (w_in_fire) begin
            r_s1_first    <= w_tile_first;
            r_s1_last     <= w_tile_last;
            r_s1_pix      <= r_pix;
            r_s1_ch1      <= in_ch1;
            r_s1_ch2      <= in_ch2;
            // RAM returns pre-write data on a same-cycle collision; capture
            // the value being written so S1 adds onto it instead.
            r_s1_fwd      <= w_we && (r_s1_pix == r_pix);
            r_s1_fwd_data <= w_wdata;
         end
      end
   end

   always_comb begin
      w_base     = r_s1_fwd ? r_s1_fwd_data : w_rd_data;
      w_base_ch1 = w_base[PSUM_W-1:0];
      w_base_ch2 = w_base[2*PSUM_W-1:PSUM_W];
      if (r_s1_first) begin
         w_sum1 = r_s1_ch1;
         w_sum2 = r_s1_ch2;
      end else begin
         w_sum1 = sat18(SUM_W'(w_base_ch1) + SUM_W'(r_s1_ch1));
         w_sum2 = sat18(SUM_W'(w_base_ch2) + SUM_W'(r_s1_ch2));
      end
      w_wdata = {w_sum2, w_sum1};
      w_we    = r_s1_valid && w_adv && !r_s1_last;
      w_q1    = post_process(w_sum1, r_cfg_shift, r_cfg_leaky);
      w_q2    = post_process(w_sum2, r_cfg_shift, r_cfg_leaky);
   end

   // ---------------- S2: output register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
      end else if (w_adv) begin
         r_s2_valid <= r_s1_valid && r_s1_last;
         if (r_s1_valid && r_s1_last)
            r_s2_data <= {w_q2, w_q1};
      end
   end

endmodule

// File: tb/tb_module_conv_psum_accum_1x2.sv
module tb_module_conv_psum_accum_1x2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] cfg_pixels = '0;
   logic [5:0]  cfg_tiles = '0;
   logic [3:0]  cfg_shift = '0;
   logic        cfg_leaky_en = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [17:0] in_ch1 = '0;
   logic [17:0] in_ch2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        busy;
   logic        done;

   module_conv_psum_accum_1x2 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .cfg_pixels   (cfg_pixels),
      .cfg_tiles    (cfg_tiles),
      .cfg_shift    (cfg_shift),
      .cfg_leaky_en (cfg_leaky_en),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_ch1       (in_ch1),
      .in_ch2       (in_ch2),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned cyc = 0;
   int unsigned last_hs_cyc = 0;
   int unsigned done_cnt = 0;
   logic [15:0] exp_q[$];
   bit          stall_req = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [15:0] e;
      bit          prev_hold;
      logic [15:0] prev_data;
      prev_hold = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_hold = 1'b0;
            continue;
         end
         if (prev_hold) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(prev_data));
         end
         if (out_valid && !out_ready)
            check("stall_in_ready", 32'(in_ready), 32'd0);
         if (done)
            done_cnt++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got %0h expected no output", out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(e));
            end
            last_hs_cyc = cyc;
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
      end
   end

   // ---------------- writer backpressure ----------------
   initial begin
      forever begin
         @(posedge clk); #1;
         if (stall_req) begin
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
            stall_req = 1'b0;
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_job(input int px, input int tl, input int sh, input bit lk);
      cfg_pixels   = 12'(px);
      cfg_tiles    = 6'(tl);
      cfg_shift    = 4'(sh);
      cfg_leaky_en = lk;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input int a, input int b);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_ch1   = 18'(a);
      in_ch2   = 18'(b);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready=0 after 300 cycles, required 1");
      end
      tick();
   endtask

   task automatic send_last(input int a, input int b, input logic [15:0] exp);
      exp_q.push_back(exp);
      send(a, b);
   endtask

   task automatic wait_done(input string name);
      bit          ok;
      int unsigned dc;
      ok = 1'b0;
      dc = 0;
      in_valid = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            dc = cyc;
            break;
         end
      end
      check({name, "_done_seen"}, 32'(ok), 32'd1);
      check({name, "_done_timing"}, dc, last_hs_cyc + 1);
      check({name, "_busy_at_done"}, 32'(busy), 32'd0);
      check({name, "_queue_drained"}, exp_q.size(), 32'd0);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int unsigned c0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // Input offered while idle must be refused and not counted.
      in_valid = 1'b1;
      in_ch1 = 18'd99;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      tick();
      in_valid = 1'b0;

      // Single tile, clamp both directions.
      start_job(4, 1, 0, 1'b0);
      send_last(5,    0,  16'h0005);
      send_last(-3,   1,  16'h01FD);
      send_last(200,  -1, 16'hFF7F);
      send_last(-200, 7,  16'h0780);
      wait_done("single");

      // Three tiles accumulated, shift 2 with rounding.
      start_job(2, 3, 2, 1'b0);
      send(100, -100); send(100, -100);
      send(100, -100); send(100, -100);
      send_last(100, -100, 16'hB54B);
      send_last(100, -100, 16'hB54B);
      wait_done("accum");

      // Leaky-ReLU on, then off.
      start_job(2, 1, 0, 1'b1);
      send_last(-64, 64, 16'h40F8);
      send_last(-64, -5, 16'hFFF8);
      wait_done("leaky_on");
      start_job(1, 1, 0, 1'b0);
      send_last(-64, -5, 16'hFBC0);
      wait_done("leaky_off");

      // Saturation at both rails, single pixel.
      start_job(1, 2, 10, 1'b0);
      send(131071, -131072);
      send_last(131071, -131072, 16'h807F);
      wait_done("sat");

      // Back-to-back single-pixel tiles: each sum depends on the previous write.
      start_job(1, 3, 0, 1'b0);
      send(10, -1);
      send(20, -2);
      send_last(30, -3, 16'hFA3C);
      wait_done("hazard");

      // Writer stalls 5 cycles during the last tile.
      start_job(4, 2, 0, 1'b0);
      send(1, -1); send(2, -2); send(3, -3); send(4, -4);
      send_last(10, 100, 16'h630B);
      stall_req = 1'b1;
      send_last(20, 100, 16'h6216);
      send_last(30, 100, 16'h6121);
      send_last(40, 100, 16'h602C);
      wait_done("stall");

      // Zero-sized jobs: one busy cycle, then done.
      start_job(0, 3, 0, 1'b0);
      @(negedge clk);
      check("zero_px_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("zero_px_done", 32'(done), 32'd1);
      check("zero_px_busy_low", 32'(busy), 32'd0);
      tick();
      start_job(5, 0, 0, 1'b0);
      @(negedge clk);
      check("zero_tl_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("zero_tl_done", 32'(done), 32'd1);
      tick();

      // Reset during a middle tile, then a fresh job.
      start_job(2, 3, 0, 1'b0);
      send(1, 1); send(2, 2); send(3, 3);
      in_valid = 1'b0;
      tick();
      c0 = done_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      check("midrst_no_done", done_cnt, c0);
      start_job(2, 2, 0, 1'b0);
      send(7, -7); send(8, -8);
      send_last(1, 1, 16'hFA08);
      send_last(1, 1, 16'hF909);
      wait_done("after_rst");

      repeat (5) tick();
      check("final_queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
